// File: rtl/alu_multicycle_exec.sv
// alu_multicycle_exec: execute-stage ALU. Register ops and branch compares
// complete in one cycle. SLL/SRL shift one bit per cycle behind a
// start/busy/done handshake.
// Optional build macro: ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start_i             request, accepted while busy_o is low
//   ALU_Operation_i     4-bit operation code
//   A_i, B_i            operands (shift amount is B_i[4:0])
//   busy_o              iterative shift in progress
//   done_o              one-cycle pulse, result/flags valid
//   ALU_Result_o        registered result, held until the next done_o
//   Zero_o              result == 0
//   Branch_Taken_o      branch condition (0 for non-branch ops)
//   Illegal_o           unsupported operation code
module alu_multicycle_exec #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] ALU_Result_o,
    output logic                  Zero_o,
    output logic                  Branch_Taken_o,
    output logic                  Illegal_o
);

    localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_LUI = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_BNE = 4'b1001;
    localparam logic [3:0] OP_BLT = 4'b1010;
    localparam logic [3:0] OP_BGE = 4'b1011;
    localparam logic [3:0] OP_JAL = 4'b1100;
    localparam logic [3:0] OP_SW  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] shreg, shreg_next;
    logic [SHAMT_W-1:0]    count, count_next;
    logic                  shift_left, shift_left_next;

    logic [DATA_WIDTH-1:0] op_result;
    logic                  op_taken;
    logic                  op_illegal;
    logic                  op_iterative;
    logic [SHAMT_W-1:0]    shamt;
    logic [DATA_WIDTH-1:0] diff;

    logic                  load_out;
    logic [DATA_WIDTH-1:0] result_next;
    logic                  taken_next;
    logic                  illegal_next;

    assign shamt = B_i[SHAMT_W-1:0];
    assign diff  = A_i - B_i;

    // Single-cycle result for the incoming operation
    always_comb begin
        op_result    = '0;
        op_taken     = 1'b0;
        op_illegal   = 1'b0;
        op_iterative = 1'b0;
        unique case (ALU_Operation_i)
            OP_ADD, OP_SW: op_result = A_i + B_i;
            OP_SUB:        op_result = diff;
            OP_OR:         op_result = A_i | B_i;
            OP_AND:        op_result = A_i & B_i;
            OP_XOR:        op_result = A_i ^ B_i;
            OP_LUI:        op_result = B_i;
            OP_JAL:        op_result = A_i + DATA_WIDTH'(4);
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:        op_result = A_i << shamt;
            OP_SRL:        op_result = A_i >> shamt;
`else
            // Only reached directly for shamt == 0; non-zero amounts iterate
            OP_SLL, OP_SRL: begin
                op_result    = A_i;
                op_iterative = (shamt != '0);
            end
`endif
            OP_BEQ: begin
                op_result = diff;
                op_taken  = (A_i == B_i);
            end
            OP_BNE: begin
                op_result = diff;
                op_taken  = (A_i != B_i);
            end
            OP_BLT: begin
                op_result = diff;
                op_taken  = ($signed(A_i) < $signed(B_i));
            end
            OP_BGE: begin
                op_result = diff;
                op_taken  = ($signed(A_i) >= $signed(B_i));
            end
            default:       op_illegal = 1'b1;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_next      = state;
        shreg_next      = shreg;
        count_next      = count;
        shift_left_next = shift_left;
        load_out        = 1'b0;
        result_next     = op_result;
        taken_next      = op_taken;
        illegal_next    = op_illegal;
        unique case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start_i) begin
                    if (op_iterative) begin
                        shreg_next      = A_i;
                        count_next      = shamt;
                        shift_left_next = (ALU_Operation_i == OP_SLL);
                        state_next      = SHIFT;
                    end else begin
                        load_out   = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            SHIFT: begin
                shreg_next = shift_left ? (shreg << 1) : (shreg >> 1);
                count_next = count - SHAMT_W'(1);
                if (count == SHAMT_W'(1)) begin
                    load_out     = 1'b1;
                    result_next  = shreg_next;
                    taken_next   = 1'b0;
                    illegal_next = 1'b0;
                    state_next   = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            shreg          <= '0;
            count          <= '0;
            shift_left     <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            ALU_Result_o   <= '0;
            Zero_o         <= 1'b0;
            Branch_Taken_o <= 1'b0;
            Illegal_o      <= 1'b0;
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            count      <= count_next;
            shift_left <= shift_left_next;
            busy_o     <= (state_next == SHIFT);
            done_o     <= (state_next == DONE);
            if (load_out) begin
                ALU_Result_o   <= result_next;
                Zero_o         <= (result_next == '0);
                Branch_Taken_o <= taken_next;
                Illegal_o      <= illegal_next;
            end
        end
    end

endmodule

// File: doc/alu_multicycle_exec.md
# alu_multicycle_exec

Multi-cycle execute unit consuming the 4-bit ALU operation code produced by the ALU control decoder, plus two 32-bit operands from the datapath. Register-to-register ops and branch compares complete in one cycle; shifts run iteratively, one bit per cycle, behind a start/busy/done handshake. Sits in the execute stage between the operand muxes and the writeback/PC-select logic.

## Interface
- DATA_WIDTH, 32, operand/result width; shift amount is B_i[4:0].
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start_i  input  1  request; sampled on rising edge, accepted only when busy_o=0.
- ALU_Operation_i  input  4  operation code (table under Operation).
- A_i  input  DATA_WIDTH  operand A (rs1 or PC).
- B_i  input  DATA_WIDTH  operand B (rs2 or immediate).
- busy_o  output  1  high while an iterative shift is in progress.
- done_o  output  1  one-cycle pulse: ALU_Result_o/flags valid for the accepted op.
- ALU_Result_o  output  DATA_WIDTH  registered result; held until next done_o.
- Zero_o  output  1  ALU_Result_o == 0; updated with done_o.
- Branch_Taken_o  output  1  branch condition result; 0 for non-branch ops.
- Illegal_o  output  1  high with done_o when code is 1110/1111.

## Operation
- Codes: 0000 ADD (A+B, also addi/lw/jalr); 0001 SUB; 0010 OR; 0011 SLL; 0100 SRL (logical); 0101 LUI (result=B); 0110 AND; 0111 XOR; 1000 BEQ; 1001 BNE; 1010 BLT (signed); 1011 BGE (signed); 1100 JAL (result=A+4); 1101 SW (A+B address).
- Branch ops: result = A−B, Branch_Taken_o = condition; otherwise Branch_Taken_o = 0.
- Arithmetic modulo 2^DATA_WIDTH; carry/overflow discarded.
- Illegal codes: result 0, Zero_o=1, Branch_Taken_o=0, Illegal_o=1; done_o still pulses.
- FSM: IDLE, SHIFT, DONE.
  - IDLE/DONE + start_i, shift op, shamt k>0: latch A into shift register, count=k → SHIFT.
  - IDLE/DONE + start_i, any other op or shamt=0: compute, register result → DONE.
  - SHIFT: shift one bit per cycle (zero fill), count−1; at count=1 → DONE with final value.
  - DONE: done_o=1 for that cycle; no start_i → IDLE.
- Operands and opcode captured at acceptance; A_i/B_i may change afterwards.
- start_i while busy_o=1 ignored (not queued).
- Reset value of every output: 0 (ALU_Result_o=0, Zero_o=0, all flags 0).

## Timing
- Start accepted at edge N, non-shift or shamt=0: done_o high during cycle N+1 (latency 1).
- Shift, shamt k≥1: busy_o high cycles N+1..N+k; done_o high cycle N+k+1.
- Back-to-back: start_i asserted during DONE accepted; throughput one single-cycle op per clock.
- Outputs change only on the edge entering DONE; stable otherwise.
- reset asserted in any state: at next edge → IDLE, outputs 0, in-flight op discarded, no done_o.
- reset and start_i same edge: reset wins.

## Configuration
- ALU_FAST_SHIFT_EN defined: SLL/SRL computed by single-cycle barrel shifter; SHIFT state unused, busy_o constant 0, every op latency 1.
- Undefined (default): iterative shifter as above, latency shamt+1.

## Test plan
- Reset: hold reset 2 cycles with start_i=1 → all outputs 0, no done_o; release → IDLE.
- ADD: A=0x7FFFFFFF, B=1, code 0000 → done_o at N+1, result 0x80000000, Zero_o=0; SUB A=B=5 → result 0, Zero_o=1.
- Branch: BLT A=0xFFFFFFFF, B=1 → Branch_Taken_o=1; BGE same operands → 0; BNE A=B=3 → 0.
- Shift: SLL A=1, B=31 → busy_o 31 cycles, done_o at N+32, result 0x80000000; SRL A=0x80000000, B=0 → done_o at N+1, result 0x80000000; start_i during busy ignored.
- Reset mid-shift: SRL A=0xF0000000, B=20, reset at N+5 → no done_o, outputs 0, next ADD 2+3 → 5 at latency 1.
- Illegal 1111 → done_o, Illegal_o=1, result 0; with ALU_FAST_SHIFT_EN, SLL A=3, B=4 → result 0x30 at N+1, busy_o never high.
